mau_iterative: RTL
==================

Name: mau_iterative

Overview:
Parametrised multi-cycle multiply/divide/accumulate unit that replaces the combinational hi/lo MAU in the datapath. It runs one shift-add or restoring-divide step per clock and owns the HI/LO registers. A start/busy/done handshake lets the control unit stall the PC while an operation is in flight. It adds divide, multiply-accumulate and multiply-subtract modes, plus direct HI/LO writes.

Parameters:
WIDTH, 32, operand width and HI/LO register width in bits; legal range 4 to 64.
CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request to begin an operation; sampled only in IDLE
op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
a  input  WIDTH  rs operand (multiplicand or dividend)
b  input  WIDTH  rt operand (multiplier or divisor)
hi_we  input  1  mthi: load HI from a (honoured in IDLE only)
lo_we  input  1  mtlo: load LO from a (honoured in IDLE only)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when HI/LO are updated
div_by_zero  output  1  one-cycle pulse together with done for DIV/DIVU with b==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: on a rst-sampled edge the block goes to IDLE and drives hi=0, lo=0, busy=0, done=0, div_by_zero=0. Reset aborts any in-flight operation and discards its result.
- FSM has three states: IDLE, CALC and FINISH.
- IDLE to CALC: on an edge (edge 0) with start=1. The block latches op, |a| and |b| (magnitudes for signed ops), the result signs, and clears the counter.
- CALC: performs one iteration per edge, at edges 1..WIDTH. The counter increments each edge, and the FSM moves to FINISH when counter==WIDTH-1.
- Multiply step: shift-add over a 2*WIDTH partial product.
- Divide step: restoring division producing WIDTH quotient bits.
- FINISH to IDLE: at edge WIDTH+1 the sign fix-up and accumulate are applied, HI/LO are written, and done=1 for exactly one cycle.
- busy is high in CALC and FINISH, i.e. for WIDTH+1 cycles after start is accepted. busy=0 in the cycle where done=1.
- Back-to-back operation: start may be asserted in the cycle where done=1; it is accepted because the state is IDLE.
- start is ignored while busy; op, a and b may change freely after acceptance.
- MULT/MULTU: {hi,lo} = a*b, signed or unsigned full 2*WIDTH product.
- MADD/MADDU: {hi,lo} = {hi,lo} + product. MSUB/MSUBU: {hi,lo} = {hi,lo} - product. The arithmetic is modulo 2^(2*WIDTH), and the HI/LO value used is the one present at edge WIDTH+1.
- DIV/DIVU: lo = quotient, hi = remainder. The signed quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Signed overflow case (most-negative / -1): lo = most-negative, hi = 0, with no flag.
- Divide by zero: detected at edge 0. The block still runs the full WIDTH+1 cycles, HI/LO are left unchanged, and div_by_zero pulses with done.
- hi_we/lo_we in IDLE: load from a at the same edge. If start is also set on that edge, the write still occurs and the start is accepted.
- hi_we/lo_we while busy: the write is dropped silently.

Test Plan:
- WIDTH=32, MULT with a=-3, b=5 -> busy high for 33 cycles, then done; hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
- mtlo a=10 and mthi a=0, then MADD 4*5 -> lo=30, hi=0. Then MSUBU 40*1 -> {hi,lo} = 64'hFFFFFFFF_FFFFFFF6.
- DIVU 9/0 with hi=5, lo=6 beforehand -> done and div_by_zero pulse together at cycle 33; hi=5, lo=6 unchanged.
- start (MULT 2*3) re-asserted mid-CALC together with lo_we -> both ignored; result is lo=6. Then rst at cycle 10 of the next op -> hi=lo=0, busy=0 next cycle, and no done pulse.
- WIDTH=8, MULTU 255*255 -> hi=8'hFE, lo=8'h01, done 9 cycles after start.

Source files
------------

// File: rtl/mau_iterative_if.sv
// ============================================================================
// Module      : mau_iterative_if
// Description : Handshake/operand bundle between the control unit and the
//               iterative multiply/divide/accumulate unit.
//               master : start, op, a, b, hi_we, lo_we  ->  unit
//               slave  : busy, done, div_by_zero, hi, lo ->  control unit
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mau_iterative_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mau_iterative.sv
// ============================================================================
// Module      : mau_iterative
// Description : Multi-cycle multiply / divide / multiply-accumulate unit that
//               owns the HI/LO registers. One shift-add or restoring-divide
//               step per clock; WIDTH+1 busy cycles per operation.
// Ports       : clk          - clock, rising edge
//               rst          - synchronous reset, active-high
//               bus (slave)  - start/op/a/b/hi_we/lo_we in,
//                              busy/done/div_by_zero/hi/lo out
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mau_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mau_iterative_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic [WIDTH-1:0]    r_opnd;     // |multiplicand| or |divisor|
    logic [WIDTH-1:0]    r_wh;       // partial-product high half / remainder
    logic [WIDTH-1:0]    r_wl;       // multiplier bits / dividend -> quotient
    logic                r_neg_q;    // product or quotient must be negated
    logic                r_neg_r;    // remainder must be negated
    logic                r_dbz;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_done;
    logic                r_dbz_pulse;

    // Operand conditioning: odd opcodes are the unsigned variants.
    logic                w_a_neg;
    logic                w_b_neg;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic                w_op_div;
    logic                w_r_div;

    assign w_a_neg  = ~bus.op[0] & bus.a[WIDTH-1];
    assign w_b_neg  = ~bus.op[0] & bus.b[WIDTH-1];
    // Magnitude of the most-negative value is its own bit pattern read unsigned.
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;
    assign w_op_div = (bus.op[2:1] == 2'b01);
    assign w_r_div  = (r_op[2:1] == 2'b01);

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole 2*WIDTH pair right.
    logic [WIDTH:0]      w_add_sum;
    assign w_add_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opnd} : '0);

    // Restoring step: the shifted remainder is always below 2*divisor, so
    // bit WIDTH of the difference is a clean borrow flag.
    logic [WIDTH:0]      w_shift;
    logic [WIDTH:0]      w_diff;
    assign w_shift = {r_wh, r_wl[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_opnd};

    // Sign fix-up and accumulate.
    logic [2*WIDTH-1:0]  w_mag;
    logic [2*WIDTH-1:0]  w_prod;
    logic [2*WIDTH-1:0]  w_mac;
    logic [WIDTH-1:0]    w_quo;
    logic [WIDTH-1:0]    w_rem;

    assign w_mag  = {r_wh, r_wl};
    assign w_prod = r_neg_q ? -w_mag : w_mag;
    assign w_quo  = r_neg_q ? -r_wl : r_wl;
    assign w_rem  = r_neg_r ? -r_wh : r_wh;

    always_comb begin
        w_mac = w_prod;
        case (r_op[2:1])
            2'b10:   w_mac = {r_hi, r_lo} + w_prod;
            2'b11:   w_mac = {r_hi, r_lo} - w_prod;
            default: w_mac = w_prod;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_CALC;
            S_CALC:   if (r_cnt == c_LAST) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_opnd      <= '0;
            r_wh        <= '0;
            r_wl        <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.a;
                    if (bus.lo_we) r_lo <= bus.a;
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_opnd  <= w_b_mag;
                        r_wh    <= '0;
                        r_wl    <= w_a_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_dbz   <= w_op_div && (bus.b == '0);
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_r_div) begin
                        r_wh <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                        r_wl <= {r_wl[WIDTH-2:0], ~w_diff[WIDTH]};
                    end else begin
                        r_wh <= w_add_sum[WIDTH:1];
                        r_wl <= {w_add_sum[0], r_wl[WIDTH-1:1]};
                    end
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    if (w_r_div) begin
                        if (r_dbz) begin
                            r_dbz_pulse <= 1'b1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end else begin
                        {r_hi, r_lo} <= w_mac;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz_pulse;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

`default_nettype wire
